ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Arbitrates one RAM block-command port between an image writer and an SD reader.
// Image normally wins; a waiting SD request is forced through after SD_MAX_SKIP image grants.
module ram_port_arbiter #(
  parameter int BLOCK_WORDS = 512,
  parameter int ADDR_W      = 21,
  parameter int SD_MAX_SKIP = 3
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              img_req,
  input  logic [ADDR_W-1:0] img_addr,
  output logic              img_grant,
  output logic              img_done,
  input  logic              sd_req,
  input  logic [ADDR_W-1:0] sd_addr,
  output logic              sd_grant,
  output logic              sd_done,
  output logic              ram_cmd_valid,
  input  logic              ram_cmd_ready,
  output logic              ram_cmd_write,
  output logic [ADDR_W-1:0] ram_cmd_addr,
  input  logic              ram_word_strobe,
  output logic              busy
);

  localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       SKIP_MAX  = 4'(SD_MAX_SKIP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        skip_q, skip_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic              img_grant_q, img_grant_d;
  logic              sd_grant_q, sd_grant_d;
  logic              img_done_q, img_done_d;
  logic              sd_done_q, sd_done_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              sd_wins_s;

  // Next-state, arbitration and next-output computation
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    sd_wins_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (img_req || sd_req) begin
          sd_wins_s = sd_req && (!img_req || (skip_q == SKIP_MAX));
          write_d   = !sd_wins_s;
          addr_d    = sd_wins_s ? sd_addr : img_addr;
          state_d   = CMD;
          if (sd_wins_s) begin
            skip_d = 4'd0;
          end else if (sd_req && (skip_q < SKIP_MAX)) begin
            skip_d = skip_q + 4'd1;
          end else begin
            skip_d = skip_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CMD: begin
        // ram_cmd_valid is always high here, so ready alone completes the handshake
        if (ram_cmd_ready) begin
          state_d = XFER;
          cnt_d   = '0;
        end else begin
          state_d = CMD;
        end
      end
      XFER: begin
        if (ram_word_strobe) begin
          if (cnt_q == LAST_WORD) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DONE: begin
        // Drop the latched command so the port reads all-zero while idle
        state_d = IDLE;
        addr_d  = '0;
        write_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    img_grant_d = ((state_d == CMD) || (state_d == XFER)) && write_d;
    sd_grant_d  = ((state_d == CMD) || (state_d == XFER)) && !write_d;
    img_done_d  = (state_d == DONE) && write_d;
    sd_done_d   = (state_d == DONE) && !write_d;
    valid_d     = (state_d == CMD);
    busy_d      = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      skip_q      <= 4'd0;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      img_grant_q <= 1'b0;
      sd_grant_q  <= 1'b0;
      img_done_q  <= 1'b0;
      sd_done_q   <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      img_grant_q <= img_grant_d;
      sd_grant_q  <= sd_grant_d;
      img_done_q  <= img_done_d;
      sd_done_q   <= sd_done_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign img_grant     = img_grant_q;
  assign sd_grant      = sd_grant_q;
  assign img_done      = img_done_q;
  assign sd_done       = sd_done_q;
  assign ram_cmd_valid = valid_q;
  assign ram_cmd_write = write_q;
  assign ram_cmd_addr  = addr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter: a transaction-level model predicts the winner,
// command fields and done pulse of every block; a continuous monitor watches grants and dones.
module tb_ram_port_arbiter;
  localparam int BW   = 4;
  localparam int AW   = 21;
  localparam int MAXS = 3;

  logic          clk = 1'b0;
  logic          rst_ = 1'b0;
  logic          img_req = 1'b0, sd_req = 1'b0;
  logic [AW-1:0] img_addr = '0, sd_addr = '0;
  logic          img_grant, img_done, sd_grant, sd_done;
  logic          ram_cmd_valid, ram_cmd_write, busy;
  logic          ram_cmd_ready = 1'b0, ram_word_strobe = 1'b0;
  logic [AW-1:0] ram_cmd_addr;

  int n_tests = 0, n_fail = 0;
  int skip_m = 0;
  int exp_img_done = 0, exp_sd_done = 0;
  int img_done_cnt = 0, sd_done_cnt = 0;
  logic img_done_prev = 1'b0, sd_done_prev = 1'b0;
  bit obs_sd;

  ram_port_arbiter #(.BLOCK_WORDS(BW), .ADDR_W(AW), .SD_MAX_SKIP(MAXS)) dut (
    .clk(clk), .rst_(rst_),
    .img_req(img_req), .img_addr(img_addr), .img_grant(img_grant), .img_done(img_done),
    .sd_req(sd_req), .sd_addr(sd_addr), .sd_grant(sd_grant), .sd_done(sd_done),
    .ram_cmd_valid(ram_cmd_valid), .ram_cmd_ready(ram_cmd_ready),
    .ram_cmd_write(ram_cmd_write), .ram_cmd_addr(ram_cmd_addr),
    .ram_word_strobe(ram_word_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string ph, input bit ig, input bit sg, input bit v,
                            input bit w, input logic [AW-1:0] a, input bit idn,
                            input bit sdn, input bit b);
    check({ph, "_img_grant"}, 32'(img_grant), 32'(ig));
    check({ph, "_sd_grant"}, 32'(sd_grant), 32'(sg));
    check({ph, "_cmd_valid"}, 32'(ram_cmd_valid), 32'(v));
    check({ph, "_cmd_write"}, 32'(ram_cmd_write), 32'(w));
    check({ph, "_cmd_addr"}, 32'(ram_cmd_addr), 32'(a));
    check({ph, "_img_done"}, 32'(img_done), 32'(idn));
    check({ph, "_sd_done"}, 32'(sd_done), 32'(sdn));
    check({ph, "_busy"}, 32'(busy), 32'(b));
  endtask

  // Continuous monitor: mutual exclusion of grants and single-cycle dones
  always @(negedge clk) begin
    if (rst_) begin
      check("grant_excl", 32'(img_grant & sd_grant), 32'd0);
      check("img_done_width", 32'(img_done & img_done_prev), 32'd0);
      check("sd_done_width", 32'(sd_done & sd_done_prev), 32'd0);
      img_done_prev <= img_done;
      sd_done_prev  <= sd_done;
      if (img_done) img_done_cnt <= img_done_cnt + 1;
      if (sd_done) sd_done_cnt <= sd_done_cnt + 1;
    end else begin
      img_done_prev <= 1'b0;
      sd_done_prev  <= 1'b0;
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_block(input bit ir, input bit sr, input logic [AW-1:0] ia,
                           input logic [AW-1:0] sa, input int rdy_dly, input bit cmd_strobes,
                           input bit drop_req, input int abort_after);
    bit win_sd;
    logic [AW-1:0] ea;
    img_req = ir; sd_req = sr; img_addr = ia; sd_addr = sa;
    win_sd = (ir && sr) ? (skip_m == MAXS) : sr;
    ea = win_sd ? sa : ia;
    if (win_sd) skip_m = 0;
    else if (sr) skip_m = (skip_m + 1 > MAXS) ? MAXS : skip_m + 1;
    @(negedge clk);
    obs_sd = sd_grant;
    for (int c = 0; c <= rdy_dly; c++) begin
      expect_out("cmd", !win_sd, win_sd, 1'b1, !win_sd, ea, 1'b0, 1'b0, 1'b1);
      ram_cmd_ready   = (c == rdy_dly);
      ram_word_strobe = cmd_strobes;
      @(negedge clk);
    end
    ram_cmd_ready = 1'b0;
    ram_word_strobe = 1'b0;
    img_addr = AW'($urandom);
    sd_addr  = AW'($urandom);
    if (drop_req) begin
      if (win_sd) sd_req = 1'b0;
      else img_req = 1'b0;
    end
    for (int w = 0; w < BW; w++) begin
      if (w == abort_after) begin
        rst_ = 1'b0;
        #1;
        expect_out("rst_async", 0, 0, 0, 0, '0, 0, 0, 0);
        skip_m = 0;
        img_req = 1'b0; sd_req = 1'b0;
        @(negedge clk);
        expect_out("rst_hold", 0, 0, 0, 0, '0, 0, 0, 0);
        rst_ = 1'b1;
        repeat (2) begin
          @(negedge clk);
          expect_out("rst_after", 0, 0, 0, 0, '0, 0, 0, 0);
        end
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        expect_out("xfer", !win_sd, win_sd, 1'b0, !win_sd, ea, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
      end
      expect_out("xfer", !win_sd, win_sd, 1'b0, !win_sd, ea, 1'b0, 1'b0, 1'b1);
      ram_word_strobe = 1'b1;
      @(negedge clk);
      ram_word_strobe = 1'b0;
    end
    expect_out("done", 1'b0, 1'b0, 1'b0, !win_sd, ea, !win_sd, win_sd, 1'b1);
    if (win_sd) exp_sd_done++;
    else exp_img_done++;
    ram_word_strobe = 1'($urandom_range(0, 1));
    @(negedge clk);
    ram_word_strobe = 1'b0;
    expect_out("idle", 0, 0, 0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    // Reset and quiet idle, with stray strobes
    repeat (2) @(negedge clk);
    expect_out("reset", 0, 0, 0, 0, '0, 0, 0, 0);
    rst_ = 1'b1;
    repeat (3) begin
      ram_word_strobe = 1'($urandom_range(0, 1));
      @(negedge clk);
      expect_out("idle_quiet", 0, 0, 0, 0, '0, 0, 0, 0);
    end
    ram_word_strobe = 1'b0;

    // Image alone, addr 0x12, ready two cycles after valid
    run_block(1'b1, 1'b0, 21'h12, 21'h0, 2, 1'b0, 1'b0, -1);
    img_req = 1'b0;

    // Both held high: img, img, img, sd repeating
    for (int k = 0; k < 8; k++) begin
      run_block(1'b1, 1'b1, AW'($urandom), AW'($urandom), $urandom_range(0, 3), 1'b0, 1'b0, -1);
      check("order_sd", 32'(obs_sd), 32'(k % 4 == 3));
    end
    img_req = 1'b0; sd_req = 1'b0;
    @(negedge clk);

    // SD alone with strobes during CMD
    run_block(1'b0, 1'b1, AW'($urandom), AW'($urandom), 3, 1'b1, 1'b0, -1);
    sd_req = 1'b0;

    // Image request dropped and address changed during XFER
    run_block(1'b1, 1'b0, AW'($urandom), AW'($urandom), 1, 1'b0, 1'b1, -1);

    // Reset after 2 of 4 strobes, then a clean restart
    run_block(1'b1, 1'b0, AW'($urandom), AW'($urandom), 1, 1'b0, 1'b0, 2);
    run_block(1'b1, 1'b1, AW'($urandom), AW'($urandom), 0, 1'b0, 1'b0, -1);
    img_req = 1'b0; sd_req = 1'b0;

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      bit ir, sr;
      ir = 1'($urandom_range(0, 1));
      sr = 1'($urandom_range(0, 1));
      if (!ir && !sr) begin
        img_req = 1'b0; sd_req = 1'b0;
        @(negedge clk);
        expect_out("idle_rand", 0, 0, 0, 0, '0, 0, 0, 0);
      end else begin
        run_block(ir, sr, AW'($urandom), AW'($urandom), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      end
    end
    img_req = 1'b0; sd_req = 1'b0;
    repeat (2) @(negedge clk);

    check("img_done_count", 32'(img_done_cnt), 32'(exp_img_done));
    check("sd_done_count", 32'(sd_done_cnt), 32'(exp_sd_done));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
